// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants and state type for the serial word receiver
package rx_pkg;

   localparam int DATA_W           = 14;
   localparam int CLKS_PER_BIT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/serial_word_recovery_if.sv
// rtl/serial_word_recovery_if.sv - serial line in, recovered word and strobes out
interface serial_word_recovery_if;

   logic                       rx_serial;
   logic [rx_pkg::DATA_W-1:0]  data_rec;
   logic                       clock_recovery;
   logic                       frame_error;

   modport master (
      output rx_serial,
      input  data_rec,
      input  clock_recovery,
      input  frame_error
   );

   modport slave (
      input  rx_serial,
      output data_rec,
      output clock_recovery,
      output frame_error
   );

endinterface

// File: rtl/rx_sync_2ff.sv
// rtl/rx_sync_2ff.sv - 1-bit two-flop synchroniser, resets to 1 (idle-high lines)
module rx_sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serial_word_recovery.sv
// rtl/serial_word_recovery.sv - recovers 14-bit framed words from an async serial line
module serial_word_recovery
   import rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                   clock_50,
   input  logic                   reset_n,
   serial_word_recovery_if.slave  bus
);

   localparam int SW = $clog2(CLKS_PER_BIT);
   localparam logic [SW-1:0] SMP_HALF = SW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [SW-1:0] SMP_LAST = SW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    BIT_LAST = 4'(DATA_W - 1);

   generate
      if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
         $error("CLKS_PER_BIT must be even and at least 4");
      end
   endgenerate

   logic              rx_s;
   logic              rx_d_q;
   rx_state_t         state_q, state_d;
   logic [SW-1:0]     smp_cnt_q, smp_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_rec_q, data_rec_d;
   logic              crec_q, crec_d;
   logic              ferr_q, ferr_d;

   rx_sync_2ff u_sync (
      .clk_i  (clock_50),
      .rst_ni (reset_n),
      .d_i    (bus.rx_serial),
      .q_o    (rx_s)
   );

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         rx_d_q     <= 1'b1;
         state_q    <= IDLE;
         smp_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_rec_q <= '0;
         crec_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_d_q     <= rx_s;
         state_q    <= state_d;
         smp_cnt_q  <= smp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         data_rec_q <= data_rec_d;
         crec_q     <= crec_d;
         ferr_q     <= ferr_d;
      end
   end

   // Only a fresh high-to-low transition starts a frame, so a stuck-low line stays idle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (rx_d_q && !rx_s) state_d = START;
         START: if (smp_cnt_q == SMP_HALF) state_d = rx_s ? IDLE : DATA;
         DATA:  if (smp_cnt_q == SMP_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
         STOP:  if (smp_cnt_q == SMP_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      smp_cnt_d  = smp_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      data_rec_d = data_rec_q;
      crec_d     = 1'b0;
      ferr_d     = 1'b0;
      unique case (state_q)
         IDLE: smp_cnt_d = '0;
         START: begin
            if (smp_cnt_q == SMP_HALF) begin
               smp_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (smp_cnt_q == SMP_LAST) begin
               smp_cnt_d = '0;
               shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
               if (bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         STOP: begin
            if (smp_cnt_q == SMP_LAST) begin
               smp_cnt_d = '0;
               if (rx_s) begin
                  data_rec_d = shreg_q;
                  crec_d     = 1'b1;
               end else begin
                  ferr_d     = 1'b1;
               end
            end
         end
         default: smp_cnt_d = '0;
      endcase
   end

   assign bus.data_rec       = data_rec_q;
   assign bus.clock_recovery = crec_q;
   assign bus.frame_error    = ferr_q;

endmodule
